// File: rtl/stage4_if.sv
// Data-memory request/response port between the MEM stage and the data memory.
interface stage4_if #(
  parameter int unsigned XLEN = 64
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic            dmem_ready;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/stage4.sv
// Pipeline MEM stage: aligned data-memory access with a two-state FSM and MEM/WB register.
module stage4 #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      write_register_in,
  input  logic [2:0]      funct3_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            MemToReg_in,
  input  logic            RegWrite_in,
  stage4_if.master        dmem,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] read_data_out,
  output logic [4:0]      write_register_out,
  output logic            MemToReg_out,
  output logic            RegWrite_out,
  output logic            stall_out,
  output logic            misalign_out
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [7:0]      wstrb_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic            we_q, memread_q, memtoreg_q, regwrite_q;

  logic [XLEN-1:0] alu_result_out_q, read_data_out_q;
  logic [4:0]      write_register_out_q;
  logic            memtoreg_out_q, regwrite_out_q, misalign_q;

  logic [2:0]      off;
  logic            memop, misaligned, start;
  logic [7:0]      strb_base, wstrb_d;
  logic [XLEN-1:0] wdata_d, rdata_shift, load_data;

  assign off   = alu_result_in[2:0];
  assign memop = valid_in & (MemRead_in | MemWrite_in);

  always_comb begin
    misaligned = 1'b0;
    strb_base  = 8'h01;
    unique case (funct3_in[1:0])
      2'b00: strb_base = 8'h01;
      2'b01: begin strb_base = 8'h03; misaligned = off[0];           end
      2'b10: begin strb_base = 8'h0F; misaligned = (off[1:0] != 2'b00); end
      2'b11: begin strb_base = 8'hFF; misaligned = (off != 3'b000);     end
    endcase
    if (funct3_in == 3'b111) misaligned = 1'b1;
  end

  assign start   = memop & ~misaligned;
  assign wstrb_d = MemWrite_in ? (strb_base << off) : 8'h00;
  assign wdata_d = store_data_in << {off, 3'b000};

  // Align the addressed lane down to bit 0, then extend per access size/sign.
  assign rdata_shift = dmem.dmem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_data = rdata_shift;
    unique case (funct3_q)
      3'b000:  load_data = {{56{rdata_shift[7]}},  rdata_shift[7:0]};
      3'b001:  load_data = {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b010:  load_data = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      3'b100:  load_data = {56'd0, rdata_shift[7:0]};
      3'b101:  load_data = {48'd0, rdata_shift[15:0]};
      3'b110:  load_data = {32'd0, rdata_shift[31:0]};
      default: load_data = rdata_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= StIdle;
      addr_q               <= '0;
      wdata_q              <= '0;
      wstrb_q              <= '0;
      rd_q                 <= '0;
      funct3_q             <= '0;
      we_q                 <= 1'b0;
      memread_q            <= 1'b0;
      memtoreg_q           <= 1'b0;
      regwrite_q           <= 1'b0;
      alu_result_out_q     <= '0;
      read_data_out_q      <= '0;
      write_register_out_q <= '0;
      memtoreg_out_q       <= 1'b0;
      regwrite_out_q       <= 1'b0;
      misalign_q           <= 1'b0;
    end else begin
      // Bubble by default; overridden below when an instruction completes.
      memtoreg_out_q <= 1'b0;
      regwrite_out_q <= 1'b0;
      misalign_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StAccess;
            addr_q     <= alu_result_in;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= write_register_in;
            funct3_q   <= funct3_in;
            we_q       <= MemWrite_in;
            memread_q  <= MemRead_in;
            memtoreg_q <= MemToReg_in;
            regwrite_q <= RegWrite_in;
          end else if (memop) begin
            misalign_q <= 1'b1;
          end else if (valid_in) begin
            alu_result_out_q     <= alu_result_in;
            read_data_out_q      <= '0;
            write_register_out_q <= write_register_in;
            memtoreg_out_q       <= MemToReg_in;
            regwrite_out_q       <= RegWrite_in & (write_register_in != 5'd0);
          end
        end
        StAccess: begin
          if (dmem.dmem_ready) begin
            state_q              <= StIdle;
            alu_result_out_q     <= addr_q;
            read_data_out_q      <= memread_q ? load_data : '0;
            write_register_out_q <= rd_q;
            memtoreg_out_q       <= memtoreg_q;
            regwrite_out_q       <= regwrite_q & (rd_q != 5'd0);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem.dmem_req   = (state_q == StAccess);
  assign dmem.dmem_we    = (state_q == StAccess) & we_q;
  assign dmem.dmem_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = (state_q == StAccess) ? wstrb_q : 8'h00;

  assign stall_out = ((state_q == StIdle) & start) | ((state_q == StAccess) & ~dmem.dmem_ready);

  assign alu_result_out     = alu_result_out_q;
  assign read_data_out      = read_data_out_q;
  assign write_register_out = write_register_out_q;
  assign MemToReg_out       = memtoreg_out_q;
  assign RegWrite_out       = regwrite_out_q;
  assign misalign_out       = misalign_q;

endmodule
